// File: rtl/jtkiwi_pkg.sv
// Shared Kiwi definitions: shared-RAM arbiter states, port ids and the access
// length that the main-side wrapper also uses for its own wait timing.
package jtkiwi_pkg;

    localparam int JTKIWI_ACC_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAIN = 2'd1,
        ST_SUB  = 2'd2
    } shram_state_t;

    typedef enum logic {
        PORT_MAIN = 1'b0,
        PORT_SUB  = 1'b1
    } shram_port_t;

endpackage

// File: rtl/jtkiwi_shram_port.sv
// Per-CPU side of the shared-RAM arbiter: completion flag, read data capture
// and the wait request presented to the CPU.
module jtkiwi_shram_port (
    input  logic       clk,
    input  logic       comb_rstn,
    input  logic       cs,
    input  logic       fin,
    input  logic       rd,
    input  logic [7:0] ram_dout,
    output logic       pend,
    output logic       busy,
    output logic [7:0] dout
);

    logic done;

    assign pend = cs & ~done;
    // Wait stays up through the capture cycle, so dout is already valid once it drops.
    assign busy = pend;

    // NOTE: async reset sits in the sensitivity list; every state bit here is a
    // plain register (no memory array), so all of it is reset.
    always_ff @(posedge clk or negedge comb_rstn) begin
        if (!comb_rstn) begin
            done <= 1'b0;
            dout <= 8'd0;
        end else begin
            if (!cs)
                done <= 1'b0;
            else if (fin)
                done <= 1'b1;
            if (fin && rd)
                dout <= ram_dout;
        end
    end

endmodule

// File: rtl/jtkiwi_shram.sv
// Kiwi main/sub shared-RAM arbiter: serialises both CPU ports onto one
// single-port synchronous RAM with tie alternation and back-to-back hand-over.
module jtkiwi_shram
    import jtkiwi_pkg::*;
#(
    parameter int AW      = 13,
    parameter int ACC_CYC = JTKIWI_ACC_CYC
) (
    input  logic          clk,
    input  logic          comb_rstn,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_din,
    output logic [7:0]    main_dout,
    output logic          main_busy,
    input  logic          sub_cs,
    input  logic          sub_rnw,
    input  logic [AW-1:0] sub_addr,
    input  logic [7:0]    sub_din,
    output logic [7:0]    sub_dout,
    output logic          sub_busy,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    localparam int            CW       = $clog2(ACC_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

    shram_state_t  st, st_nx;
    shram_port_t   last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          won, won_nx;
    logic          rnw_q, rnw_nx;
    logic [AW-1:0] addr_nx;
    logic [7:0]    din_nx;
    logic          we_nx;
    logic          main_pend, sub_pend, main_fin, sub_fin, last_cyc;
    logic          grant_main, grant_sub;
    logic          main_busy_w, sub_busy_w;

    assign last_cyc = (cnt == CNT_LAST);
    assign main_fin = (st == ST_MAIN) && last_cyc;
    assign sub_fin  = (st == ST_SUB)  && last_cyc;

    jtkiwi_shram_port u_main (
        .clk       ( clk         ),
        .comb_rstn ( comb_rstn   ),
        .cs        ( main_cs     ),
        .fin       ( main_fin    ),
        .rd        ( rnw_q       ),
        .ram_dout  ( ram_dout    ),
        .pend      ( main_pend   ),
        .busy      ( main_busy_w ),
        .dout      ( main_dout   )
    );

    jtkiwi_shram_port u_sub (
        .clk       ( clk        ),
        .comb_rstn ( comb_rstn  ),
        .cs        ( sub_cs     ),
        .fin       ( sub_fin    ),
        .rd        ( rnw_q      ),
        .ram_dout  ( ram_dout   ),
        .pend      ( sub_pend   ),
        .busy      ( sub_busy_w ),
        .dout      ( sub_dout   )
    );

    assign main_busy = main_busy_w;
    assign sub_busy  = sub_busy_w;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        st_nx      = st;
        last_nx    = last;
        cnt_nx     = cnt;
        won_nx     = won;
        rnw_nx     = rnw_q;
        addr_nx    = ram_addr;
        din_nx     = ram_din;
        we_nx      = 1'b0;
        grant_main = 1'b0;
        grant_sub  = 1'b0;

        case (st)
            ST_IDLE: begin
                if (main_pend && (!sub_pend || last == PORT_SUB))
                    grant_main = 1'b1;
                else if (sub_pend)
                    grant_sub = 1'b1;
            end
            ST_MAIN: begin
                cnt_nx = cnt + CW'(1);
                if (last_cyc) begin
                    // Only an IDLE win moves the tie-break, so repeated ties alternate.
                    if (won)
                        last_nx = PORT_MAIN;
                    cnt_nx    = '0;
                    st_nx     = ST_IDLE;
                    grant_sub = sub_pend;
                end
            end
            ST_SUB: begin
                cnt_nx = cnt + CW'(1);
                if (last_cyc) begin
                    if (won)
                        last_nx = PORT_SUB;
                    cnt_nx     = '0;
                    st_nx      = ST_IDLE;
                    grant_main = main_pend;
                end
            end
            default: st_nx = ST_IDLE;
        endcase

        if (grant_main) begin
            st_nx   = ST_MAIN;
            cnt_nx  = '0;
            won_nx  = (st == ST_IDLE);
            rnw_nx  = main_rnw;
            addr_nx = main_addr;
            din_nx  = main_din;
            we_nx   = ~main_rnw;
        end else if (grant_sub) begin
            st_nx   = ST_SUB;
            cnt_nx  = '0;
            won_nx  = (st == ST_IDLE);
            rnw_nx  = sub_rnw;
            addr_nx = sub_addr;
            din_nx  = sub_din;
            we_nx   = ~sub_rnw;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or negedge comb_rstn) begin
        if (!comb_rstn) begin
            st       <= ST_IDLE;
            last     <= PORT_SUB;
            cnt      <= '0;
            won      <= 1'b0;
            rnw_q    <= 1'b1;
            ram_addr <= '0;
            ram_din  <= 8'd0;
            ram_we   <= 1'b0;
        end else begin
            st       <= st_nx;
            last     <= last_nx;
            cnt      <= cnt_nx;
            won      <= won_nx;
            rnw_q    <= rnw_nx;
            ram_addr <= addr_nx;
            ram_din  <= din_nx;
            ram_we   <= we_nx;
        end
    end

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Scoreboard bench for jtkiwi_shram: behavioural RAM, high-level service-order
// model, per-port completion monitors and a RAM write monitor.
module tb_jtkiwi_shram;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          comb_rstn = 1'b0;
    logic          main_cs = 1'b0, main_rnw = 1'b1;
    logic [AW-1:0] main_addr = '0;
    logic [7:0]    main_din = 8'd0;
    logic [7:0]    main_dout;
    logic          main_busy;
    logic          sub_cs = 1'b0, sub_rnw = 1'b1;
    logic [AW-1:0] sub_addr = '0;
    logic [7:0]    sub_din = 8'd0;
    logic [7:0]    sub_dout;
    logic          sub_busy;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout = 8'd0;

    always #5 clk = ~clk;

    jtkiwi_shram #(.AW(AW), .ACC_CYC(2)) dut (
        .clk       ( clk       ),
        .comb_rstn ( comb_rstn ),
        .main_cs   ( main_cs   ),
        .main_rnw  ( main_rnw  ),
        .main_addr ( main_addr ),
        .main_din  ( main_din  ),
        .main_dout ( main_dout ),
        .main_busy ( main_busy ),
        .sub_cs    ( sub_cs    ),
        .sub_rnw   ( sub_rnw   ),
        .sub_addr  ( sub_addr  ),
        .sub_din   ( sub_din   ),
        .sub_dout  ( sub_dout  ),
        .sub_busy  ( sub_busy  ),
        .ram_addr  ( ram_addr  ),
        .ram_din   ( ram_din   ),
        .ram_we    ( ram_we    ),
        .ram_dout  ( ram_dout  )
    );

    // Single-port synchronous RAM, one cycle read latency
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    typedef struct { logic [7:0] data; int lat; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    exp_t q_main[$];
    exp_t q_sub[$];
    wr_t  q_wr[$];

    logic [7:0] ref_mem [0:8191];
    logic [7:0] ref_dout [2];
    int         ref_last;   // port that last won arbitration: 0 main, 1 sub

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: apply one access in service order and record what the DUT must show
    task automatic serve(input int p, input logic rnw, input logic [AW-1:0] addr,
                         input logic [7:0] din, input int lat);
        exp_t e;
        wr_t  w;
        if (!rnw) begin
            ref_mem[addr] = din;
            w.addr = addr;
            w.data = din;
            q_wr.push_back(w);
        end else begin
            ref_dout[p] = ref_mem[addr];
        end
        e.data = ref_dout[p];
        e.lat  = lat;
        if (p == 0) q_main.push_back(e);
        else        q_sub.push_back(e);
    endtask

    // Completion monitor: busy falling while cs is held ends an access
    int   bcnt [2];
    logic pbusy [2];

    task automatic mon_port(input int p, input logic cs, input logic busy, input logic [7:0] dout);
        exp_t e;
        logic have;
        have = 1'b0;
        if (!cs) begin
            bcnt[p] = 0;
        end else if (busy) begin
            bcnt[p]++;
        end else if (pbusy[p]) begin
            if (p == 0) begin
                have = (q_main.size() > 0);
                if (have) e = q_main.pop_front();
            end else begin
                have = (q_sub.size() > 0);
                if (have) e = q_sub.pop_front();
            end
            check(p == 0 ? "main_expected_access" : "sub_expected_access", have, 1'b1);
            if (have) begin
                check(p == 0 ? "main_dout" : "sub_dout", dout, e.data);
                check(p == 0 ? "main_busy_cycles" : "sub_busy_cycles", bcnt[p], e.lat);
            end
            bcnt[p] = 0;
        end
        pbusy[p] = busy & cs;
    endtask

    always @(negedge clk) begin
        if (!comb_rstn) begin
            bcnt[0] = 0; bcnt[1] = 0;
            pbusy[0] = 1'b0; pbusy[1] = 1'b0;
        end else begin
            mon_port(0, main_cs, main_busy, main_dout);
            mon_port(1, sub_cs, sub_busy, sub_dout);
        end
    end

    // RAM write monitor: every strobe must match the next modelled write
    always @(negedge clk) begin
        wr_t  w;
        logic have;
        if (comb_rstn && ram_we) begin
            have = (q_wr.size() > 0);
            check("ram_we_expected", have, 1'b1);
            if (have) begin
                w = q_wr.pop_front();
                check("ram_addr", ram_addr, w.addr);
                check("ram_din", ram_din, w.data);
            end
        end
    end

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!main_busy && !sub_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("access_timeout", ok, 1'b1);
    endtask

    task automatic access(input logic m_en, input logic m_rnw, input logic [AW-1:0] m_addr,
                          input logic [7:0] m_din, input logic s_en, input logic s_rnw,
                          input logic [AW-1:0] s_addr, input logic [7:0] s_din);
        if (m_en && s_en) begin
            if (ref_last == 1) begin
                serve(0, m_rnw, m_addr, m_din, 3);
                serve(1, s_rnw, s_addr, s_din, 5);
                ref_last = 0;
            end else begin
                serve(1, s_rnw, s_addr, s_din, 3);
                serve(0, m_rnw, m_addr, m_din, 5);
                ref_last = 1;
            end
        end else if (m_en) begin
            serve(0, m_rnw, m_addr, m_din, 3);
            ref_last = 0;
        end else if (s_en) begin
            serve(1, s_rnw, s_addr, s_din, 3);
            ref_last = 1;
        end
        @(posedge clk); #1;
        main_cs = m_en; main_rnw = m_rnw; main_addr = m_addr; main_din = m_din;
        sub_cs  = s_en; sub_rnw  = s_rnw; sub_addr  = s_addr; sub_din  = s_din;
        wait_idle();
        @(posedge clk); #1;
        main_cs = 1'b0;
        sub_cs  = 1'b0;
    endtask

    task automatic model_reset();
        ref_last    = 1;
        ref_dout[0] = 8'd0;
        ref_dout[1] = 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_we"}, ram_we, 1'b0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_din"}, ram_din, 0);
        check({tag, "_main_dout"}, main_dout, 0);
        check({tag, "_sub_dout"}, sub_dout, 0);
        check({tag, "_main_busy"}, main_busy, 1'b0);
        check({tag, "_sub_busy"}, sub_busy, 1'b0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 13'h1FFF;
            1:       return 13'h0000;
            default: return AW'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'd0;
            ref_mem[i] = 8'd0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 comb_rstn = 1'b1;
        check_reset_outputs("reset");

        // Sub read alone
        mem[13'h0123]     = 8'h5A;
        ref_mem[13'h0123] = 8'h5A;
        access(1'b0, 1'b1, '0, 8'd0, 1'b1, 1'b1, 13'h0123, 8'd0);

        // Main write at top address, then sub reads it back
        access(1'b1, 1'b0, 13'h1FFF, 8'hA5, 1'b0, 1'b1, '0, 8'd0);
        access(1'b0, 1'b1, '0, 8'd0, 1'b1, 1'b1, 13'h1FFF, 8'd0);

        // Ties right after reset: main first, then sub first on the repeat
        @(posedge clk); #1 comb_rstn = 1'b0;
        model_reset();
        @(posedge clk); #1 comb_rstn = 1'b1;
        access(1'b1, 1'b1, 13'h0123, 8'd0, 1'b1, 1'b1, 13'h1FFF, 8'd0);
        access(1'b1, 1'b0, 13'h0010, 8'h11, 1'b1, 1'b0, 13'h0010, 8'h22);
        access(1'b1, 1'b1, 13'h0010, 8'd0, 1'b0, 1'b1, '0, 8'd0);

        // Sub cs held after completion: no re-issue until cs drops
        serve(1, 1'b0, 13'h0020, 8'h77, 3);
        ref_last = 1;
        @(posedge clk); #1;
        sub_cs = 1'b1; sub_rnw = 1'b0; sub_addr = 13'h0020; sub_din = 8'h77;
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("sub_busy_held_cs", sub_busy, 1'b0);
        end
        @(posedge clk); #1 sub_cs = 1'b0;
        access(1'b0, 1'b1, '0, 8'd0, 1'b1, 1'b0, 13'h0020, 8'h88);
        access(1'b0, 1'b1, '0, 8'd0, 1'b1, 1'b1, 13'h0020, 8'd0);

        // Reset during a main write grant: strobe drops, write is lost
        @(posedge clk); #1;
        main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h0042; main_din = 8'h99;
        @(posedge clk); #1;
        check("we_at_grant", ram_we, 1'b1);
        comb_rstn = 1'b0;
        main_cs   = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(posedge clk); #1 comb_rstn = 1'b1;
        access(1'b1, 1'b1, 13'h0042, 8'd0, 1'b0, 1'b1, '0, 8'd0);

        // Main cs drops right after grant: access still completes
        ref_dout[0] = ref_mem[13'h1FFF];
        ref_last    = 0;
        @(posedge clk); #1;
        main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h1FFF;
        @(posedge clk); #1 main_cs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("main_dout_after_drop", main_dout, ref_dout[0]);
        check("main_busy_after_drop", main_busy, 1'b0);
        access(1'b0, 1'b1, '0, 8'd0, 1'b1, 1'b1, 13'h0123, 8'd0);
        access(1'b1, 1'b1, 13'h0123, 8'd0, 1'b0, 1'b1, '0, 8'd0);

        // Randomised mix of single and simultaneous accesses
        for (int n = 0; n < 60; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            access(mode != 1, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom_range(0, 255)),
                   mode != 0, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom_range(0, 255)));
        end

        repeat (4) @(posedge clk);
        check("main_queue_drained", q_main.size(), 0);
        check("sub_queue_drained", q_sub.size(), 0);
        check("write_queue_drained", q_wr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
